wormhole_switch_allocator: RTL and testbench

WORMHOLE_SWITCH_ALLOCATOR -- requirements
Module: wormhole_switch_allocator

---
 rtl/noc_params.sv | 14 +
 rtl/wormhole_switch_allocator_arb.sv | 29 ++
 rtl/wormhole_switch_allocator.sv | 157 +++++++++++++++
 tb/tb_wormhole_switch_allocator.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
// Shared NoC router parameters: port count and the port direction type.
package noc_params;

    localparam int PORT_NUM = 5;

    typedef enum logic [2:0] {
        LOCAL,
        NORTH,
        SOUTH,
        WEST,
        EAST
    } port_t;

endpackage

// File: rtl/wormhole_switch_allocator_arb.sv
// Combinational round-robin arbiter: first request at or after ptr_i, cyclically.
module round_robin_arbiter #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic         valid_o
);

    always_comb begin
        logic found;
        int   idx;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/wormhole_switch_allocator.sv
// Wormhole switch allocator with per-output locks, round-robin and credits.
// Optional sticky credit overflow flag credit_err_o under SA_CREDIT_ERR_EN.
module wormhole_switch_allocator
    import noc_params::*;
#(
    parameter int PORT_NUM     = 5,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic  [PORT_NUM-1:0]                  valid_i,
    input  port_t [PORT_NUM-1:0]                  out_port_i,
    input  logic  [PORT_NUM-1:0]                  head_i,
    input  logic  [PORT_NUM-1:0]                  tail_i,
    input  logic  [PORT_NUM-1:0]                  credit_i,
    output logic  [PORT_NUM-1:0]                  grant_o,
    output logic  [PORT_NUM-1:0]                  sel_valid_o,
`ifdef SA_CREDIT_ERR_EN
    output logic                                  credit_err_o,
`endif
    output logic  [PORT_NUM-1:0][$clog2(PORT_NUM)-1:0] sel_o
);

    localparam int SEL_W = $clog2(PORT_NUM);
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_DEPTH);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(PORT_NUM - 1);

    logic [PORT_NUM-1:0]             lock_q, lock_d;
    logic [PORT_NUM-1:0][SEL_W-1:0]  owner_q, owner_d;
    logic [PORT_NUM-1:0][SEL_W-1:0]  ptr_q, ptr_d;
    logic [PORT_NUM-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [PORT_NUM-1:0]             ovf;

    logic [PORT_NUM-1:0] req      [PORT_NUM];
    logic [PORT_NUM-1:0] head_req [PORT_NUM];
    logic [PORT_NUM-1:0] arb_gnt  [PORT_NUM];
    logic                arb_vld  [PORT_NUM];
    logic [PORT_NUM-1:0] gnt      [PORT_NUM];

    // req[o][i]: input i has a flit headed for output o
    always_comb begin
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                req[o][i] = valid_i[i] && (out_port_i[i] == port_t'(o));
            end
            head_req[o] = req[o] & head_i;
        end
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_arb
        round_robin_arbiter #(
            .N (PORT_NUM),
            .W (SEL_W)
        ) u_arb (
            .req_i   (head_req[o]),
            .ptr_i   (ptr_q[o]),
            .gnt_o   (arb_gnt[o]),
            .valid_o (arb_vld[o])
        );
    end

    always_comb begin
        for (int o = 0; o < PORT_NUM; o++) begin
            gnt[o] = '0;
            if (!rst && cnt_q[o] != '0) begin
                if (lock_q[o]) begin
                    if (req[o][owner_q[o]]) begin
                        gnt[o][owner_q[o]] = 1'b1;
                    end
                end else if (arb_vld[o]) begin
                    gnt[o] = arb_gnt[o];
                end
            end
        end
    end

    always_comb begin
        grant_o     = '0;
        sel_valid_o = '0;
        sel_o       = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            sel_valid_o[o] = |gnt[o];
            for (int i = 0; i < PORT_NUM; i++) begin
                if (gnt[o][i]) begin
                    grant_o[i] = 1'b1;
                    sel_o[o]   = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf     = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            if (sel_valid_o[o]) begin
                if (lock_q[o]) begin
                    if (tail_i[owner_q[o]]) begin
                        lock_d[o] = 1'b0;
                    end
                end else begin
                    ptr_d[o] = (sel_o[o] == LAST) ? '0 : sel_o[o] + 1'b1;
                    if (!tail_i[sel_o[o]]) begin
                        lock_d[o]  = 1'b1;
                        owner_d[o] = sel_o[o];
                    end
                end
            end
            // a credit cancels a same-cycle grant; one beyond full is dropped
            if (credit_i[o] && !sel_valid_o[o]) begin
                if (cnt_q[o] == FULL) begin
                    ovf[o] = 1'b1;
                end else begin
                    cnt_d[o] = cnt_q[o] + 1'b1;
                end
            end else if (!credit_i[o] && sel_valid_o[o]) begin
                cnt_d[o] = cnt_q[o] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= {PORT_NUM{FULL}};
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SA_CREDIT_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (|ovf) begin
            err_q <= 1'b1;
        end
    end

    assign credit_err_o = err_q;
`else
    logic unused_ovf;
    assign unused_ovf = ^ovf;
`endif

endmodule

// File: tb/tb_wormhole_switch_allocator.sv
// Table-driven bench with a scoreboard queue for wormhole_switch_allocator.
module tb_wormhole_switch_allocator;
    import noc_params::*;

    localparam logic [2:0] PL = 3'd0;
    localparam logic [2:0] PN = 3'd1;
    localparam logic [2:0] PS = 3'd2;
    localparam logic [2:0] PW = 3'd3;
    localparam logic [2:0] PE = 3'd4;
    localparam logic [2:0] Z  = 3'd0;

    typedef struct {
        logic [4:0]      v, h, t, c;
        logic [4:0][2:0] op;
        logic [4:0]      g, sv;
        logic [4:0][2:0] sel;
    } vec_t;

    typedef struct {
        logic [4:0]      g, sv;
        logic [4:0][2:0] sel;
        int              id;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      valid, head, tail, credit;
    port_t [4:0]     op;
    logic [4:0]      grant, selv;
    logic [4:0][2:0] sel;
`ifdef SA_CREDIT_ERR_EN
    logic            cerr;
`endif

    int   pass_cnt = 0;
    int   total    = 0;
    exp_t sbq[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    wormhole_switch_allocator #(
        .PORT_NUM     (5),
        .BUFFER_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid),
        .out_port_i   (op),
        .head_i       (head),
        .tail_i       (tail),
        .credit_i     (credit),
        .grant_o      (grant),
        .sel_valid_o  (selv),
`ifdef SA_CREDIT_ERR_EN
        .credit_err_o (cerr),
`endif
        .sel_o        (sel)
    );

    function automatic vec_t mk(
        input logic [4:0] v, input logic [14:0] o,
        input logic [4:0] h, input logic [4:0] t, input logic [4:0] c,
        input logic [4:0] g, input logic [4:0] sv, input logic [14:0] s
    );
        vec_t r;
        r.v = v; r.op = o; r.h = h; r.t = t; r.c = c;
        r.g = g; r.sv = sv; r.sel = s;
        return r;
    endfunction

    task automatic cmp(input string nm, input int id,
                       input logic [14:0] act, input logic [14:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s vec%0d: got %h want %h", nm, id, act, exp);
    endtask

    task automatic check();
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            $display("FAIL scoreboard: no expected entry");
            return;
        end
        e = sbq.pop_front();
        cmp("grant", e.id, 15'(grant), 15'(e.g));
        cmp("sel_valid", e.id, 15'(selv), 15'(e.sv));
        cmp("sel", e.id, sel, e.sel);
    endtask

    task automatic step(input vec_t x, input int id);
        exp_t e;
        valid  = x.v;
        head   = x.h;
        tail   = x.t;
        credit = x.c;
        for (int i = 0; i < 5; i++) op[i] = port_t'(x.op[i]);
        e.g = x.g; e.sv = x.sv; e.sel = x.sel; e.id = id;
        sbq.push_back(e);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // two-packet EAST contention, then ptr=3 picks input 3 over input 1
        tbl.push_back(mk(5'b00101, {Z,Z,PE,Z,PE}, 5'b00101, 5'b00101, 5'b0,
                         5'b00001, 5'b10000, 15'd0));
        tbl.push_back(mk(5'b00100, {Z,Z,PE,Z,Z}, 5'b00100, 5'b00100, 5'b0,
                         5'b00100, 5'b10000, {3'd2,Z,Z,Z,Z}));
        tbl.push_back(mk(5'b01010, {Z,PE,Z,PE,Z}, 5'b01010, 5'b01010, 5'b0,
                         5'b01000, 5'b10000, {3'd3,Z,Z,Z,Z}));
        // 4-flit packet from input 1 to NORTH holds off input 3
        tbl.push_back(mk(5'b01010, {Z,PN,Z,PN,Z}, 5'b01010, 5'b01000, 5'b0,
                         5'b00010, 5'b00010, {Z,Z,Z,3'd1,Z}));
        tbl.push_back(mk(5'b01010, {Z,PN,Z,PN,Z}, 5'b01000, 5'b01000, 5'b0,
                         5'b00010, 5'b00010, {Z,Z,Z,3'd1,Z}));
        tbl.push_back(mk(5'b01010, {Z,PN,Z,PN,Z}, 5'b01000, 5'b01000, 5'b00010,
                         5'b00010, 5'b00010, {Z,Z,Z,3'd1,Z}));
        tbl.push_back(mk(5'b01010, {Z,PN,Z,PN,Z}, 5'b01000, 5'b01010, 5'b00010,
                         5'b00010, 5'b00010, {Z,Z,Z,3'd1,Z}));
        tbl.push_back(mk(5'b01000, {Z,PN,Z,Z,Z}, 5'b01000, 5'b01000, 5'b0,
                         5'b01000, 5'b00010, {Z,Z,Z,3'd3,Z}));
        // SOUTH credits drain after 4 grants, one credit reopens it
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(5'b00001, {Z,Z,Z,Z,PS}, 5'b00001, 5'b00001, 5'b0,
                             5'b00001, 5'b00100, 15'd0));
        tbl.push_back(mk(5'b00001, {Z,Z,Z,Z,PS}, 5'b00001, 5'b00001, 5'b0,
                         5'b0, 5'b0, 15'd0));
        tbl.push_back(mk(5'b00001, {Z,Z,Z,Z,PS}, 5'b00001, 5'b00001, 5'b00100,
                         5'b0, 5'b0, 15'd0));
        tbl.push_back(mk(5'b00001, {Z,Z,Z,Z,PS}, 5'b00001, 5'b00001, 5'b0,
                         5'b00001, 5'b00100, 15'd0));
        // WEST: grant+credit at count 2 keeps 2, so exactly 2 more grants
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(5'b00100, {Z,Z,PW,Z,Z}, 5'b00100, 5'b00100,
                             (k == 2) ? 5'b01000 : 5'b0,
                             5'b00100, 5'b01000, {Z,3'd2,Z,Z,Z}));
        tbl.push_back(mk(5'b00100, {Z,Z,PW,Z,Z}, 5'b00100, 5'b00100, 5'b0,
                         5'b0, 5'b0, 15'd0));
        // LOCAL: credit on a full counter saturates at 4
        tbl.push_back(mk(5'b0, 15'd0, 5'b0, 5'b0, 5'b00001,
                         5'b0, 5'b0, 15'd0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(5'b00010, {Z,Z,Z,PL,Z}, 5'b00010, 5'b00010, 5'b0,
                             5'b00010, 5'b00001, {Z,Z,Z,Z,3'd1}));
        tbl.push_back(mk(5'b00010, {Z,Z,Z,PL,Z}, 5'b00010, 5'b00010, 5'b0,
                         5'b0, 5'b0, 15'd0));

        rst = 1'b1;
        valid = '0; head = '0; tail = '0; credit = '0;
        for (int i = 0; i < 5; i++) op[i] = LOCAL;
        repeat (2) @(posedge clk);
        #1;
        step(mk(5'b11111, {PE,PW,PS,PN,PL}, 5'b11111, 5'b11111, 5'b0,
                5'b0, 5'b0, 15'd0), 0);
        rst = 1'b0;

        for (int k = 0; k < tbl.size(); k++) step(tbl[k], k + 1);

`ifdef SA_CREDIT_ERR_EN
        cmp("credit_err_set", 99, 15'(cerr), 15'd1);
`endif

        // mid-packet reset while WEST is locked to input 4
        rst = 1'b1;
        step(mk(5'b0, 15'd0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 15'd0), 100);
        rst = 1'b0;
`ifdef SA_CREDIT_ERR_EN
        cmp("credit_err_clr", 100, 15'(cerr), 15'd0);
`endif
        step(mk(5'b10000, {PW,Z,Z,Z,Z}, 5'b10000, 5'b0, 5'b0,
                5'b10000, 5'b01000, {Z,3'd4,Z,Z,Z}), 101);
        step(mk(5'b10000, {PW,Z,Z,Z,Z}, 5'b0, 5'b0, 5'b0,
                5'b10000, 5'b01000, {Z,3'd4,Z,Z,Z}), 102);
        rst = 1'b1;
        for (int k = 0; k < 2; k++)
            step(mk(5'b10010, {PW,Z,Z,PW,Z}, 5'b00010, 5'b00010, 5'b0,
                    5'b0, 5'b0, 15'd0), 103 + k);
        rst = 1'b0;
        step(mk(5'b10010, {PW,Z,Z,PW,Z}, 5'b00010, 5'b00010, 5'b0,
                5'b00010, 5'b01000, {Z,3'd1,Z,Z,Z}), 105);

        // every input to a distinct output in the same cycle
        step(mk(5'b11111, {PL,PE,PW,PS,PN}, 5'b11111, 5'b11111, 5'b0,
                5'b11111, 5'b11111, {3'd3,3'd2,3'd1,3'd0,3'd4}), 106);

        if (sbq.size() != 0) begin
            total++;
            $display("FAIL scoreboard: %0d entries left, want 0", sbq.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
